// File: rtl/sub_result_display_pkg.sv
// Shared definitions for the subtract-result display slice: FSM states and
// 7-segment glyph constants, bit order {g,f,e,d,c,b,a}, active-high.
package sub_result_display_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CORRECT,
        S_SHOW
    } state_t;

    localparam logic [6:0] GLYPH_0     = 7'h3F;
    localparam logic [6:0] GLYPH_1     = 7'h06;
    localparam logic [6:0] GLYPH_2     = 7'h5B;
    localparam logic [6:0] GLYPH_3     = 7'h4F;
    localparam logic [6:0] GLYPH_4     = 7'h66;
    localparam logic [6:0] GLYPH_5     = 7'h6D;
    localparam logic [6:0] GLYPH_6     = 7'h7D;
    localparam logic [6:0] GLYPH_7     = 7'h07;
    localparam logic [6:0] GLYPH_8     = 7'h7F;
    localparam logic [6:0] GLYPH_9     = 7'h6F;
    localparam logic [6:0] GLYPH_A     = 7'h77;
    localparam logic [6:0] GLYPH_B     = 7'h7C;
    localparam logic [6:0] GLYPH_C     = 7'h39;
    localparam logic [6:0] GLYPH_D     = 7'h5E;
    localparam logic [6:0] GLYPH_E     = 7'h79;
    localparam logic [6:0] GLYPH_F     = 7'h71;
    localparam logic [6:0] GLYPH_MINUS = 7'h40;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;

endpackage

// File: rtl/sub_result_display_seg7.sv
// seg7_hex_decoder: 4-bit value to active-high 7-segment hex glyph, combinational.
module seg7_hex_decoder
    import sub_result_display_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] glyph
);

    // Hex lookup table.
    always_comb begin
        glyph = GLYPH_BLANK;
        case (value)
            4'h0: glyph = GLYPH_0;
            4'h1: glyph = GLYPH_1;
            4'h2: glyph = GLYPH_2;
            4'h3: glyph = GLYPH_3;
            4'h4: glyph = GLYPH_4;
            4'h5: glyph = GLYPH_5;
            4'h6: glyph = GLYPH_6;
            4'h7: glyph = GLYPH_7;
            4'h8: glyph = GLYPH_8;
            4'h9: glyph = GLYPH_9;
            4'hA: glyph = GLYPH_A;
            4'hB: glyph = GLYPH_B;
            4'hC: glyph = GLYPH_C;
            4'hD: glyph = GLYPH_D;
            4'hE: glyph = GLYPH_E;
            4'hF: glyph = GLYPH_F;
            default: glyph = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/sub_result_display.sv
// sub_result_display: corrects ones'-complement subtract output into
// sign+magnitude, holds it, and drives a 2-digit multiplexed 7-seg display.
// Build option: SEG_ACTIVE_LOW_EN inverts seg/an for common-anode boards.
module sub_result_display
    import sub_result_display_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int TIMEOUT      = 15,
    parameter int REFRESH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             done,
    input  logic [WIDTH-1:0] sum,
    input  logic             co,
    output logic [WIDTH-1:0] result,
    output logic             neg,
    output logic             valid,
    output logic             busy,
    output logic             timeout_err,
    output logic [6:0]       seg,
    output logic [1:0]       an
);

    localparam int CNT_W = $clog2(TIMEOUT);

`ifdef SEG_ACTIVE_LOW_EN
    localparam logic [6:0] SEG_POL = '1;
    localparam logic [1:0] AN_POL  = '1;
`else
    localparam logic [6:0] SEG_POL = '0;
    localparam logic [1:0] AN_POL  = '0;
`endif

    state_t             state, state_next;
    logic [CNT_W-1:0]   wait_cnt, wait_cnt_next;
    logic [WIDTH-1:0]   raw_sum, raw_sum_next;
    logic               raw_co, raw_co_next;
    logic [WIDTH-1:0]   result_next;
    logic               neg_next;
    logic               terr_next;
    logic [WIDTH-1:0]   inv_sum;

    logic [REFRESH_LOG2-1:0] refresh_cnt;
    logic                    digit_sel;
    logic [6:0]              mag_glyph;
    logic [6:0]              seg_raw;
    logic [1:0]              an_raw;

    assign inv_sum = ~raw_sum;
    assign busy    = (state == S_WAIT) || (state == S_CORRECT);
    assign valid   = (state == S_SHOW);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            raw_sum     <= '0;
            raw_co      <= 1'b0;
            result      <= '0;
            neg         <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            wait_cnt    <= wait_cnt_next;
            raw_sum     <= raw_sum_next;
            raw_co      <= raw_co_next;
            result      <= result_next;
            neg         <= neg_next;
            timeout_err <= terr_next;
        end
    end

    // Next-state, capture, timeout and end-around-carry correction.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        raw_sum_next  = raw_sum;
        raw_co_next   = raw_co;
        result_next   = result;
        neg_next      = neg;
        terr_next     = timeout_err;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next    = S_WAIT;
                    terr_next     = 1'b0;
                    wait_cnt_next = '0;
                end
            end
            S_WAIT: begin
                if (done) begin
                    raw_sum_next = sum;
                    raw_co_next  = co;
                    state_next   = S_CORRECT;
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    terr_next  = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    wait_cnt_next = wait_cnt + CNT_W'(1);
                end
            end
            S_CORRECT: begin
                if (raw_co) begin
                    result_next = raw_sum + WIDTH'(1);
                    neg_next    = 1'b0;
                end else begin
                    // A zero magnitude is reported as positive.
                    result_next = inv_sum;
                    neg_next    = |inv_sum;
                end
                state_next = S_SHOW;
            end
            S_SHOW: begin
                if (start) begin
                    state_next    = S_WAIT;
                    wait_cnt_next = '0;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Free-running refresh counter; digit select toggles on each wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh_cnt <= '0;
            digit_sel   <= 1'b0;
        end else begin
            refresh_cnt <= refresh_cnt + REFRESH_LOG2'(1);
            if (&refresh_cnt) begin
                digit_sel <= ~digit_sel;
            end
        end
    end

    seg7_hex_decoder u_dec (
        .value (4'(result)),
        .glyph (mag_glyph)
    );

    // Select the glyph for the active digit (active-high form).
    always_comb begin
        seg_raw = GLYPH_BLANK;
        an_raw  = 2'b01;
        if (!digit_sel) begin
            an_raw = 2'b01;
            if (valid) begin
                seg_raw = mag_glyph;
            end else if (timeout_err) begin
                seg_raw = GLYPH_E;
            end
        end else begin
            an_raw = 2'b10;
            if (valid && neg) begin
                seg_raw = GLYPH_MINUS;
            end
        end
    end

    // Display output register; board polarity is applied only here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg <= GLYPH_BLANK ^ SEG_POL;
            an  <= 2'b01 ^ AN_POL;
        end else begin
            seg <= seg_raw ^ SEG_POL;
            an  <= an_raw ^ AN_POL;
        end
    end

endmodule

// File: tb/tb_sub_result_display.sv
// Directed self-checking bench for sub_result_display.
// Build with SEG_ACTIVE_LOW_EN defined to check the inverted display polarity.
module tb_sub_result_display;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       done;
    logic [3:0] sum;
    logic       co;
    logic [3:0] result;
    logic       neg;
    logic       valid;
    logic       busy;
    logic       timeout_err;
    logic [6:0] seg;
    logic [1:0] an;

    int checks = 0;
    int passed = 0;

    sub_result_display #(
        .WIDTH        (4),
        .TIMEOUT      (15),
        .REFRESH_LOG2 (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .done        (done),
        .sum         (sum),
        .co          (co),
        .result      (result),
        .neg         (neg),
        .valid       (valid),
        .busy        (busy),
        .timeout_err (timeout_err),
        .seg         (seg),
        .an          (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [6:0] xs(input logic [6:0] s);
`ifdef SEG_ACTIVE_LOW_EN
        return ~s;
`else
        return s;
`endif
    endfunction

    function automatic logic [1:0] xa(input logic [1:0] a);
`ifdef SEG_ACTIVE_LOW_EN
        return ~a;
`else
        return a;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Wait (bounded) until the requested digit is enabled, then check its glyph.
    task automatic check_digit(input string tag, input logic [1:0] want_an, input logic [6:0] want_seg);
        step();
        for (int i = 0; i < 40 && an !== xa(want_an); i++) step();
        check({tag, "_an"}, 32'(an), 32'(xa(want_an)));
        check({tag, "_seg"}, 32'(seg), 32'(xs(want_seg)));
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; done = 1'b0; co = 1'b0; sum = 4'h0;
        step(); step();
        check("rst_result", 32'(result), 0);
        check("rst_neg", 32'(neg), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_terr", 32'(timeout_err), 0);
        check("rst_an", 32'(an), 32'(xa(2'b01)));
        check("rst_seg", 32'(seg), 32'(xs(7'h00)));
        rst = 1'b1;
        step();

        // 5-3: co=1 sum=1 -> 2, positive
        do_start();
        check("t1_busy", 32'(busy), 1);
        step(); step();
        done = 1'b1; co = 1'b1; sum = 4'h1;
        step();
        done = 1'b0;
        check("t1_valid_early", 32'(valid), 0);
        check("t1_busy_corr", 32'(busy), 1);
        step();
        check("t1_valid", 32'(valid), 1);
        check("t1_result", 32'(result), 2);
        check("t1_neg", 32'(neg), 0);
        check("t1_busy_show", 32'(busy), 0);
        check_digit("t1_mag", 2'b01, 7'h5B);
        check_digit("t1_sign", 2'b10, 7'h00);

        // 3-5: co=0 sum=D -> 2, negative
        do_start();
        check("t2_valid_clr", 32'(valid), 0);
        check("t2_busy", 32'(busy), 1);
        done = 1'b1; co = 1'b0; sum = 4'hD;
        step();
        done = 1'b0;
        step();
        check("t2_result", 32'(result), 2);
        check("t2_neg", 32'(neg), 1);
        check("t2_valid", 32'(valid), 1);
        check_digit("t2_sign", 2'b10, 7'h40);
        check_digit("t2_mag", 2'b01, 7'h5B);

        // equal operands: co=0 sum=F -> 0, no minus zero
        do_start();
        done = 1'b1; co = 1'b0; sum = 4'hF;
        step();
        done = 1'b0;
        step();
        check("t3_result", 32'(result), 0);
        check("t3_neg", 32'(neg), 0);
        check_digit("t3_sign", 2'b10, 7'h00);
        check_digit("t3_mag", 2'b01, 7'h3F);

        // timeout after 15 waiting cycles
        do_start();
        repeat (14) step();
        check("t4_busy_pre", 32'(busy), 1);
        check("t4_terr_pre", 32'(timeout_err), 0);
        step();
        check("t4_terr", 32'(timeout_err), 1);
        check("t4_busy", 32'(busy), 0);
        check("t4_valid", 32'(valid), 0);
        check_digit("t4_mag", 2'b01, 7'h79);
        check_digit("t4_sign", 2'b10, 7'h00);
        do_start();
        check("t4_terr_clr", 32'(timeout_err), 0);
        check("t4_busy_restart", 32'(busy), 1);

        // async reset mid-WAIT
        step(); step();
        rst = 1'b0;
        #1;
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_valid", 32'(valid), 0);
        check("t5_rst_terr", 32'(timeout_err), 0);
        check("t5_rst_an", 32'(an), 32'(xa(2'b01)));
        check("t5_rst_seg", 32'(seg), 32'(xs(7'h00)));
        #3;
        rst = 1'b1;
        step();

        // start with done in IDLE: done ignored
        start = 1'b1; done = 1'b1; co = 1'b1; sum = 4'h7;
        step();
        start = 1'b0; done = 1'b0;
        check("t5_busy", 32'(busy), 1);
        step();
        check("t5_done_ignored", 32'(valid), 0);
        check("t5_still_busy", 32'(busy), 1);
        // done on the final waiting cycle beats the timeout
        repeat (13) step();
        check("t5_busy_pre", 32'(busy), 1);
        check("t5_terr_pre", 32'(timeout_err), 0);
        done = 1'b1; co = 1'b1; sum = 4'h7;
        step();
        done = 1'b0;
        check("t5_done_wins_terr", 32'(timeout_err), 0);
        check("t5_done_wins_busy", 32'(busy), 1);
        step();
        check("t5_valid", 32'(valid), 1);
        check("t5_result", 32'(result), 8);
        check("t5_neg", 32'(neg), 0);
        check_digit("t5_mag", 2'b01, 7'h7F);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
